fifo_sync_param: RTL and testbench

Parametrised synchronous FIFO; the next generation of the 16×32 FIFO used between the ALU register file and the DMA datapath. Data width and depth are set per instance. It adds programmable almost-full and almost-empty thresholds, a synchronous flush, and defined simultaneous read/write behaviour at the full and empty boundaries. Per-request handshake pulses and an occupancy count are compatible with the existing FIFO status interface.

---
 rtl/fifo_sync_param_if.sv | 30 +++
 rtl/fifo_sync_param.sv | 56 +++++
 tb/tb_fifo_sync_param.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/fifo_sync_param_if.sv
// fifo_sync_param_if: request/data/status bundle between a FIFO and its user
interface fifo_sync_param_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 4
) ();
  logic                  clear;
  logic                  wr_en;
  logic [DATA_WIDTH-1:0] d_in;
  logic                  rd_en;
  logic [DATA_WIDTH-1:0] d_out;
  logic                  full;
  logic                  empty;
  logic                  almost_full;
  logic                  almost_empty;
  logic                  wr_ack;
  logic                  wr_err;
  logic                  rd_ack;
  logic                  rd_err;
  logic [ADDR_WIDTH:0]   data_count;
  modport master (
    output clear, wr_en, d_in, rd_en,
    input  d_out, full, empty, almost_full, almost_empty,
    input  wr_ack, wr_err, rd_ack, rd_err, data_count
  );
  modport slave (
    input  clear, wr_en, d_in, rd_en,
    output d_out, full, empty, almost_full, almost_empty,
    output wr_ack, wr_err, rd_ack, rd_err, data_count
  );
endinterface

// File: rtl/fifo_sync_param.sv
// fifo_sync_param: parametrised synchronous FIFO with thresholds, flush and handshake pulses
module fifo_sync_param #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 4,
  parameter int AF_LEVEL   = 14,
  parameter int AE_LEVEL   = 2
) (
  input logic              clk,
  input logic              reset_n,
  fifo_sync_param_if.slave bus
);
  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam int CW    = ADDR_WIDTH + 1;
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_WIDTH-1:0] head, tail;
  logic                  wr_ok, rd_ok;
  // acceptance uses the pre-edge count, so full+both reads and empty+both writes
  assign wr_ok = bus.wr_en && int'(bus.data_count) < DEPTH;
  assign rd_ok = bus.rd_en && bus.data_count != '0;
  assign bus.full         = int'(bus.data_count) == DEPTH;
  assign bus.empty        = bus.data_count == '0;
  assign bus.almost_full  = int'(bus.data_count) >= AF_LEVEL;
  assign bus.almost_empty = int'(bus.data_count) <= AE_LEVEL;
  always_ff @(posedge clk)
    if (wr_ok && !bus.clear) mem[tail] <= bus.d_in;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      head           <= '0;
      tail           <= '0;
      bus.data_count <= '0;
      bus.d_out      <= '0;
      bus.wr_ack     <= 1'b0;
      bus.wr_err     <= 1'b0;
      bus.rd_ack     <= 1'b0;
      bus.rd_err     <= 1'b0;
    end else if (bus.clear) begin
      head           <= '0;
      tail           <= '0;
      bus.data_count <= '0;
      bus.wr_ack     <= 1'b0;
      bus.wr_err     <= 1'b0;
      bus.rd_ack     <= 1'b0;
      bus.rd_err     <= 1'b0;
    end else begin
      if (wr_ok) tail <= tail + ADDR_WIDTH'(1);
      if (rd_ok) begin
        head      <= head + ADDR_WIDTH'(1);
        bus.d_out <= mem[head];
      end
      bus.data_count <= bus.data_count + CW'(wr_ok) - CW'(rd_ok);
      bus.wr_ack     <= wr_ok;
      bus.wr_err     <= bus.wr_en && !wr_ok;
      bus.rd_ack     <= rd_ok;
      bus.rd_err     <= bus.rd_en && !rd_ok;
    end
endmodule

// File: tb/tb_fifo_sync_param.sv
// tb_fifo_sync_param: directed checks of the default 16x32 FIFO and a 4x8 instance
module tb_fifo_sync_param;
  logic clk = 1'b0;
  logic reset_n = 1'b1;
  int vectors = 0;
  int miscompares = 0;
  logic [31:0] q[$];
  logic [31:0] dh = '0;
  logic [7:0] q8[$];
  logic [7:0] dh8 = '0;
  always #5 clk = ~clk;
  fifo_sync_param_if #(.DATA_WIDTH(32), .ADDR_WIDTH(4)) bus ();
  fifo_sync_param_if #(.DATA_WIDTH(8), .ADDR_WIDTH(2)) bus8 ();
  fifo_sync_param #(.DATA_WIDTH(32), .ADDR_WIDTH(4), .AF_LEVEL(14), .AE_LEVEL(2)) dut (
    .clk(clk), .reset_n(reset_n), .bus(bus)
  );
  fifo_sync_param #(.DATA_WIDTH(8), .ADDR_WIDTH(2), .AF_LEVEL(3), .AE_LEVEL(1)) dut8 (
    .clk(clk), .reset_n(reset_n), .bus(bus8)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic cyc(input logic w, input logic r, input logic [31:0] d);
    logic wok, rok;
    int n;
    wok = w && q.size() < 16;
    rok = r && q.size() > 0;
    bus.wr_en = w;
    bus.rd_en = r;
    bus.d_in  = d;
    if (rok) dh = q.pop_front();
    if (wok) q.push_back(d);
    n = q.size();
    @(posedge clk);
    #1;
    chk("wr_ack", 32'(bus.wr_ack), 32'(wok));
    chk("wr_err", 32'(bus.wr_err), 32'(w && !wok));
    chk("rd_ack", 32'(bus.rd_ack), 32'(rok));
    chk("rd_err", 32'(bus.rd_err), 32'(r && !rok));
    chk("d_out", bus.d_out, dh);
    chk("count", 32'(bus.data_count), 32'(n));
    chk("full", 32'(bus.full), 32'(n == 16));
    chk("empty", 32'(bus.empty), 32'(n == 0));
    chk("almost_full", 32'(bus.almost_full), 32'(n >= 14));
    chk("almost_empty", 32'(bus.almost_empty), 32'(n <= 2));
    bus.wr_en = 1'b0;
    bus.rd_en = 1'b0;
  endtask
  task automatic cyc8(input logic w, input logic r, input logic [7:0] d);
    logic wok, rok;
    int n;
    wok = w && q8.size() < 4;
    rok = r && q8.size() > 0;
    bus8.wr_en = w;
    bus8.rd_en = r;
    bus8.d_in  = d;
    if (rok) dh8 = q8.pop_front();
    if (wok) q8.push_back(d);
    n = q8.size();
    @(posedge clk);
    #1;
    chk("s_wr_ack", 32'(bus8.wr_ack), 32'(wok));
    chk("s_wr_err", 32'(bus8.wr_err), 32'(w && !wok));
    chk("s_rd_ack", 32'(bus8.rd_ack), 32'(rok));
    chk("s_rd_err", 32'(bus8.rd_err), 32'(r && !rok));
    chk("s_d_out", 32'(bus8.d_out), 32'(dh8));
    chk("s_count", 32'(bus8.data_count), 32'(n));
    chk("s_full", 32'(bus8.full), 32'(n == 4));
    chk("s_empty", 32'(bus8.empty), 32'(n == 0));
    chk("s_almost_full", 32'(bus8.almost_full), 32'(n >= 3));
    chk("s_almost_empty", 32'(bus8.almost_empty), 32'(n <= 1));
    bus8.wr_en = 1'b0;
    bus8.rd_en = 1'b0;
  endtask
  initial begin
    int n;
    logic w, r;
    bus.clear = 1'b0;
    bus.wr_en = 1'b0;
    bus.rd_en = 1'b0;
    bus.d_in  = '0;
    bus8.clear = 1'b0;
    bus8.wr_en = 1'b0;
    bus8.rd_en = 1'b0;
    bus8.d_in  = '0;
    #2 reset_n = 1'b0;
    #1;
    chk("rst_empty", 32'(bus.empty), 32'd1);
    chk("rst_count", 32'(bus.data_count), 32'd0);
    chk("rst_d_out", bus.d_out, 32'd0);
    chk("rst_full", 32'(bus.full), 32'd0);
    chk("rst_af", 32'(bus.almost_full), 32'd0);
    chk("rst_ae", 32'(bus.almost_empty), 32'd1);
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    cyc(1, 0, 32'h11);
    cyc(1, 0, 32'h22);
    cyc(0, 1, 32'h0);
    chk("basic_first", bus.d_out, 32'h11);
    cyc(0, 1, 32'h0);
    chk("basic_second", bus.d_out, 32'h22);
    cyc(0, 1, 32'h0);
    cyc(0, 1, 32'h0);
    chk("underflow_hold", bus.d_out, 32'h22);
    cyc(0, 0, 32'h0);
    for (int i = 0; i < 17; i++) cyc(1, 0, 32'h100 + 32'(i));
    chk("sat_count", 32'(bus.data_count), 32'd16);
    cyc(1, 1, 32'h1FF);
    chk("full_both_d", bus.d_out, 32'h100);
    chk("full_both_cnt", 32'(bus.data_count), 32'd15);
    for (int i = 0; i < 15; i++) cyc(0, 1, 32'h0);
    cyc(1, 1, 32'hAA);
    chk("empty_both_cnt", 32'(bus.data_count), 32'd1);
    chk("empty_both_d", bus.d_out, 32'h10F);
    for (int i = 0; i < 4; i++) cyc(1, 0, 32'hB0 + 32'(i));
    for (int i = 0; i < 10; i++) cyc(1, 1, 32'hC0 + 32'(i));
    n = 0;
    for (int k = 0; n < 40 && k < 400; k++) begin
      w = q.size() < 10 && k % 3 != 2;
      r = q.size() > 3 && (k % 2 == 0 || q.size() >= 10);
      cyc(w, r, 32'h1000 + 32'(n));
      if (w) n++;
    end
    chk("wrap_words", 32'(n), 32'd40);
    while (q.size() > 0) cyc(0, 1, 32'h0);
    for (int i = 0; i < 9; i++) cyc(1, 0, 32'h200 + 32'(i));
    bus.clear = 1'b1;
    bus.wr_en = 1'b1;
    bus.d_in  = 32'h2FF;
    @(posedge clk);
    #1;
    bus.clear = 1'b0;
    bus.wr_en = 1'b0;
    q.delete();
    chk("clr_count", 32'(bus.data_count), 32'd0);
    chk("clr_empty", 32'(bus.empty), 32'd1);
    chk("clr_wr_ack", 32'(bus.wr_ack), 32'd0);
    chk("clr_d_out", bus.d_out, dh);
    cyc(1, 0, 32'h300);
    cyc(0, 1, 32'h0);
    for (int i = 0; i < 3; i++) cyc(1, 0, 32'h400 + 32'(i));
    #2 reset_n = 1'b0;
    #1;
    q.delete();
    q8.delete();
    dh = '0;
    dh8 = '0;
    chk("mid_rst_count", 32'(bus.data_count), 32'd0);
    chk("mid_rst_empty", 32'(bus.empty), 32'd1);
    chk("mid_rst_d_out", bus.d_out, 32'd0);
    @(posedge clk);
    #1 reset_n = 1'b1;
    cyc(1, 0, 32'h500);
    cyc(0, 1, 32'h0);
    for (int i = 0; i < 5; i++) cyc8(1, 0, 8'h30 + 8'(i));
    cyc8(1, 1, 8'hEE);
    while (q8.size() > 0) cyc8(0, 1, 8'h0);
    cyc8(0, 1, 8'h0);
    n = 0;
    for (int k = 0; n < 20 && k < 200; k++) begin
      w = q8.size() < 3 && k % 3 != 2;
      r = q8.size() > 1 && (k % 2 == 0 || q8.size() >= 3);
      cyc8(w, r, 8'h60 + 8'(n));
      if (w) n++;
    end
    chk("s_wrap_words", 32'(n), 32'd20);
    while (q8.size() > 0) cyc8(0, 1, 8'h0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
